// File: rtl/tdm_demux14.sv
// tdm_demux14: receive side of a 4-slot TDM link. Serialized samples are
// steered into per-slot staging, and the four channels are published to y
// together only when a complete, correctly framed set of beats has arrived.
// A sync marker out of place drops lock or restarts the frame.
module tdm_demux14 #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           sync,
    output logic [4*W-1:0] y,
    output logic           frame_done,
    output logic           locked,
    output logic           sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state;
    logic [1:0]          slot;   // next expected slot while LOCKED
    logic [2:0][W-1:0]   stg;    // staging for slots 0..2; slot 3 comes straight from din

    // locked mirrors the state flop directly, so it is itself registered
    assign locked = (state == LOCKED);

    // Frame FSM: slot tracking, staging writes and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= 2'd0;
            stg        <= '0;
            y          <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            // pulses default low; at most one of them is set below
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        // non-sync beats are dropped silently until a frame start shows up
                        if (sync) begin
                            stg[0] <= din;
                            slot   <= 2'd1;
                            state  <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (slot == 2'd0) begin
                            if (sync) begin
                                stg[0] <= din;
                                slot   <= 2'd1;
                            end else begin
                                // expected a frame start and got data: lock is lost
                                sync_err <= 1'b1;
                                slot     <= 2'd0;
                                state    <= HUNT;
                            end
                        end else if (sync) begin
                            // premature sync: abandon the partial frame, restart on this beat
                            sync_err <= 1'b1;
                            stg[0]   <= din;
                            slot     <= 2'd1;
                        end else if (slot == 2'd3) begin
                            y          <= {din, stg[2], stg[1], stg[0]};
                            frame_done <= 1'b1;
                            slot       <= 2'd0;
                        end else begin
                            if (slot == 2'd1) stg[1] <= din;
                            else              stg[2] <= din;
                            slot <= slot + 2'd1;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tdm_demux14.md
# tdm_demux14

Sequential 1-to-4 time-division demultiplexer: the receive end of a 4-slot TDM link whose transmit end is a 4:1 slot mux. It takes one W-bit sample per valid beat plus a slot-0 sync marker, steers each sample into channel staging, and publishes all four channels atomically once per complete frame. It also detects sync loss and re-locks automatically.

## Interface
- W, default 4: sample width per channel.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  serialized sample.
- din_valid  input  1  din/sync qualify this cycle.
- sync  input  1  high on slot-0 beat only; ignored unless din_valid.
- y  output  4*W  frame output; y[W-1:0]=ch0 … y[4W-1:3W]=ch3.
- frame_done  output  1  one-cycle pulse: y updated this cycle.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on sync violation.

## Operation
- States: HUNT (unlocked), LOCKED. Reset → HUNT.
- slot: 2-bit counter, next expected slot. Staging registers s0..s2, W bits each.
- Beats are cycles with din_valid=1. Cycles with din_valid=0 change nothing; counter and staging hold, with no timeout.
- HUNT:
  - A beat with sync=1 stores din into s0, sets slot=1 and moves to LOCKED.
  - A beat with sync=0 is discarded and raises no error.
- LOCKED, slot=0:
  - A beat with sync=1 stores into s0 and sets slot=1.
  - A beat with sync=0 pulses sync_err, discards din and returns to HUNT.
- LOCKED, slot=1..3:
  - A beat with sync=1 is a premature sync. It pulses sync_err, discards the partial frame, stores din into s0, sets slot=1 and stays LOCKED.
  - A beat with sync=0 at slot 1 or 2 stores din into s1 or s2 and increments slot.
  - A beat with sync=0 at slot 3 loads y = {din, s2, s1, s0} and pulses frame_done. slot wraps to 0.
- y changes only on a completed frame. A partial or aborted frame never reaches y.
- sync_err and frame_done are never asserted in the same cycle.

## Timing
- All outputs are registered.
- Latency: the slot-3 beat at edge N makes y and frame_done valid after edge N and held until edge N+1. frame_done is then deasserted unless another frame completes.
- sync_err is a single-cycle pulse registered from the violating beat.
- locked follows the state register. It rises after the first sync beat and falls after an out-of-frame beat.
- Back-to-back frames at one beat per cycle produce frame_done every 4 cycles with no bubble.
- Reset values: y=0, frame_done=0, locked=0, sync_err=0, slot=0, s0..s2=0, state=HUNT.
- Reset mid-frame clears all of the above immediately, asynchronously. Deassertion is synchronous to clk, and the first edge after deassertion processes normally.

## Test plan
- Reset then one clean frame.
  - Stimulus: W=4, beats 4'h1(sync), 4'h2, 4'h3, 4'h4 on consecutive cycles.
  - Required: y=16'h4321 with frame_done high exactly one cycle, the cycle after the 4'h4 beat; locked=1; sync_err never asserted.
- Gapped beats.
  - Stimulus: the same frame with din_valid=0 for 3 cycles between every beat.
  - Required: identical y=16'h4321, and frame_done only after the last beat.
- Premature sync.
  - Stimulus: 4'hA(sync), 4'hB, then 4'hC(sync), 4'hD, 4'hE, 4'hF.
  - Required: sync_err pulses on the 4'hC beat, y stays at its prior value, then y=16'hFEDC with frame_done; locked never drops.
- Missing sync.
  - Stimulus: frame 1,2,3,4 followed by a beat 4'h5 with sync=0.
  - Required: sync_err pulse, locked=0, y still 16'h4321. A following 4'h6 beat with sync=0 gives no further sync_err. Then frame 6(sync),7,8,9 gives y=16'h9876.
- HUNT discard.
  - Stimulus: after reset, three beats with sync=0, then a clean frame.
  - Required: no sync_err and no frame_done until that frame completes.
- Async reset mid-frame.
  - Stimulus: after 2 beats of a frame, pulse rst_n low between edges.
  - Required: all outputs 0 immediately, locked=0; the next frame starting with sync decodes correctly.
